fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: MEM_TIMEOUT, 8, max cycles spent in MEM_WAIT without mem_ready before fault (range 1..15).
REQ-002 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: clear_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: start  in  1  request one instruction fetch; sampled only in IDLE.
REQ-005 Port: mem_ready  in  1  memory read data valid on Mdatain this cycle.
REQ-006 Port: ack_fault  in  1  clears FAULT state.
REQ-007 Ports: pc_out, mar_in, inc_pc, z_in  out  1 each  T0 datapath strobes.
REQ-008 Ports: zlow_out, pc_in  out  1 each  T1 datapath strobes.
REQ-009 Ports: mem_read, mdr_sel, mdr_in  out  1 each  memory read / MDR load strobes.
REQ-010 Ports: mdr_out, ir_in  out  1 each  T2 datapath strobes.
REQ-011 Port: busy  out  1  high in every state except IDLE and FAULT.
REQ-012 Port: done  out  1  one-cycle pulse in the cycle ir_in is asserted.
REQ-013 Port: fault  out  1  high while in FAULT.
REQ-014 Port: fetch_count  out  16  count of completed fetches.

Function
REQ-015 States: IDLE, T0, T1, MEM_WAIT, T2, FAULT; encoding in shared package.
REQ-016 IDLE: all strobes low; start=1 -> T0 next edge; start=0 -> stay.
REQ-017 T0 (one cycle): pc_out, mar_in, inc_pc, z_in high; -> T1.
REQ-018 T1 (one cycle): zlow_out, pc_in high; -> MEM_WAIT; wait counter loaded to 0.
REQ-019 MEM_WAIT: mem_read, mdr_sel high every cycle; mdr_in = mem_ready (Mealy, same cycle).
REQ-020 MEM_WAIT: mem_ready=1 -> T2; else wait counter +1; counter reaching MEM_TIMEOUT with mem_ready=0 -> FAULT.
REQ-021 mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT: ready wins, -> T2, no fault.
REQ-022 T2 (one cycle): mdr_out, ir_in, done high; fetch_count +1; -> IDLE.
REQ-023 Fetch latency with mem_ready high on first MEM_WAIT cycle: start sampled -> ir_in exactly 4 cycles later (T0,T1,MEM_WAIT,T2).
REQ-024 All strobes except mdr_in are Moore decodes of state; no two states assert the same bus-driver strobe (pc_out, zlow_out, mdr_out mutually exclusive).
REQ-025 start ignored outside IDLE; start held high causes back-to-back fetches with one IDLE cycle between T2 and next T0.
REQ-026 FAULT: all strobes low, fault=1; ack_fault=1 -> IDLE next edge; start ignored.
REQ-027 fetch_count wraps 16'hFFFF -> 16'h0000 without flag; does not increment on fault.
REQ-028 mem_ready outside MEM_WAIT has no effect.

Reset
REQ-029 clear_n=0 immediately (asynchronously) forces IDLE, wait counter 0, fetch_count 0, all outputs 0, regardless of state.
REQ-030 Reset in any state (incl. mid MEM_WAIT) abandons the fetch; no done pulse; first edge after release with start=1 enters T0.

Structure
REQ-031 Shared package holds state enum and MEM_TIMEOUT default; strobe names match datapath control names.
REQ-032 Single module; wait counter and fetch counter inline, no sub-module.

Verification
REQ-033 Reset then start=1 one cycle, mem_ready=1 -> strobes T0,T1,MEM_WAIT(mdr_in=1),T2 in order; done on cycle 4; fetch_count=1.
REQ-034 mem_ready delayed 3 MEM_WAIT cycles -> mem_read high 4 cycles, mdr_in only on 4th, ir_in next cycle, no fault.
REQ-035 mem_ready never asserted, MEM_TIMEOUT=8 -> FAULT after 8 MEM_WAIT cycles, fault=1, fetch_count unchanged; ack_fault -> IDLE.
REQ-036 mem_ready coincident with timeout cycle -> T2, done pulse, fault stays 0.
REQ-037 clear_n pulsed low mid MEM_WAIT between edges -> outputs 0 immediately, no done, fetch_count 0.
REQ-038 start held high, fetch_count preloaded by 65535 fetches -> next done wraps fetch_count to 0; T2->IDLE->T0 spacing observed.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction-fetch sequencer: state encoding, timeout
// default and the datapath strobe bundle decoded from state.
package fetch_sequencer_pkg;

    localparam int MEM_TIMEOUT_DEFAULT = 8;
    localparam int WAIT_CNT_W          = 4;
    localparam int FETCH_CNT_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_T0       = 3'd1,
        ST_T1       = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_T2       = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    // Moore strobes only; mdr_in depends on mem_ready and is handled in the top.
    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic zlow_out;
        logic pc_in;
        logic mem_read;
        logic mdr_sel;
        logic mdr_out;
        logic ir_in;
    } strobes_t;

    function automatic strobes_t decode_strobes(input state_t st);
        strobes_t s;
        s = '0;
        case (st)
            ST_T0: begin
                s.pc_out = 1'b1;
                s.mar_in = 1'b1;
                s.inc_pc = 1'b1;
                s.z_in   = 1'b1;
            end
            ST_T1: begin
                s.zlow_out = 1'b1;
                s.pc_in    = 1'b1;
            end
            ST_MEM_WAIT: begin
                s.mem_read = 1'b1;
                s.mdr_sel  = 1'b1;
            end
            ST_T2: begin
                s.mdr_out = 1'b1;
                s.ir_in   = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control sequencer: drives T0/T1/MEM_WAIT/T2 datapath
// strobes, bounds the memory wait with a timeout, and counts completed fetches.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | no strobes, waiting for start
//  T0       | PC onto bus, load MAR, increment PC into Z
//  T1       | Z low onto bus, load PC
//  MEM_WAIT | memory read in progress, MDR loads when mem_ready
//  T2       | MDR onto bus, load IR, done pulse, count the fetch
//  FAULT    | memory never answered; held until ack_fault
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   start,
    input  logic                   mem_ready,
    input  logic                   ack_fault,
    output logic                   pc_out,
    output logic                   mar_in,
    output logic                   inc_pc,
    output logic                   z_in,
    output logic                   zlow_out,
    output logic                   pc_in,
    output logic                   mem_read,
    output logic                   mdr_sel,
    output logic                   mdr_in,
    output logic                   mdr_out,
    output logic                   ir_in,
    output logic                   busy,
    output logic                   done,
    output logic                   fault,
    output logic [FETCH_CNT_W-1:0] fetch_count
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_q, wait_d, wait_inc;
    logic [FETCH_CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
    strobes_t                strb;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        fetch_cnt_d = fetch_cnt_q;
        wait_inc    = wait_q + 4'd1;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_T0;
            end
            ST_T0: state_d = ST_T1;
            ST_T1: begin
                state_d = ST_MEM_WAIT;
                wait_d  = '0;
            end
            ST_MEM_WAIT: begin
                // Ready is checked first so a late answer on the last allowed
                // cycle still completes the fetch instead of faulting.
                if (mem_ready) begin
                    state_d = ST_T2;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) state_d = ST_FAULT;
                end
            end
            ST_T2: begin
                state_d     = ST_IDLE;
                fetch_cnt_d = fetch_cnt_q + 16'd1;
            end
            ST_FAULT: begin
                if (ack_fault) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        strb = decode_strobes(state_q);
    end

    assign pc_out      = strb.pc_out;
    assign mar_in      = strb.mar_in;
    assign inc_pc      = strb.inc_pc;
    assign z_in        = strb.z_in;
    assign zlow_out    = strb.zlow_out;
    assign pc_in       = strb.pc_in;
    assign mem_read    = strb.mem_read;
    assign mdr_sel     = strb.mdr_sel;
    assign mdr_in      = (state_q == ST_MEM_WAIT) && mem_ready;
    assign mdr_out     = strb.mdr_out;
    assign ir_in       = strb.ir_in;
    assign done        = strb.ir_in;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign fault       = (state_q == ST_FAULT);
    assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues the expected output
// vector for each cycle, a negedge monitor pops and compares.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int TMO = 8;

    // {pc_out,mar_in,inc_pc,z_in, zlow_out,pc_in, mem_read,mdr_sel,mdr_in, mdr_out,ir_in, busy,done,fault}
    localparam logic [13:0] V_IDLE = 14'b0000_00_000_00_000;
    localparam logic [13:0] V_T0   = 14'b1111_00_000_00_100;
    localparam logic [13:0] V_T1   = 14'b0000_11_000_00_100;
    localparam logic [13:0] V_MW   = 14'b0000_00_110_00_100;
    localparam logic [13:0] V_MWR  = 14'b0000_00_111_00_100;
    localparam logic [13:0] V_T2   = 14'b0000_00_000_11_110;
    localparam logic [13:0] V_FLT  = 14'b0000_00_000_00_001;

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    logic start = 1'b0;
    logic mem_ready = 1'b0;
    logic ack_fault = 1'b0;
    logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in;
    logic mem_read, mdr_sel, mdr_in, mdr_out, ir_in, busy, done, fault;
    logic [15:0] fetch_count;

    fetch_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .mem_ready   (mem_ready),
        .ack_fault   (ack_fault),
        .pc_out      (pc_out),
        .mar_in      (mar_in),
        .inc_pc      (inc_pc),
        .z_in        (z_in),
        .zlow_out    (zlow_out),
        .pc_in       (pc_in),
        .mem_read    (mem_read),
        .mdr_sel     (mdr_sel),
        .mdr_in      (mdr_in),
        .mdr_out     (mdr_out),
        .ir_in       (ir_in),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [13:0] vec;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] cnt_m = '0;

    always @(negedge clock) begin
        logic [13:0] got;
        exp_t        e;
        got = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in,
               mem_read, mdr_sel, mdr_in, mdr_out, ir_in, busy, done, fault};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s cyc=%0d not observed, required vec=%b cnt=%h", e.tag, e.cyc, e.vec, e.cnt);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (got !== e.vec || fetch_count !== e.cnt) begin
                miscompares++;
                $display("FAIL %s cyc=%0d got vec=%b cnt=%h required vec=%b cnt=%h",
                         e.tag, cyc, got, fetch_count, e.vec, e.cnt);
            end
        end
    end

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    // Called at posedge+1: drive inputs for this cycle, queue what the outputs must be.
    task automatic step(input logic s, input logic r, input logic a,
                        input logic [13:0] v, input string tag);
        start     = s;
        mem_ready = r;
        ack_fault = a;
        exp_q.push_back('{cyc, v, cnt_m, tag});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, rnd(), 1'b0, V_IDLE, "idle");
    endtask

    // d: MEM_WAIT cycle index on which mem_ready rises (>= TMO means never).
    // abort_at: MEM_WAIT index at which clear_n is pulsed (-1 for none).
    task automatic fetch(input int d, input int abort_at, input bit skip_idle, input bit hold);
        logic r;
        if (!skip_idle) step(1'b1, rnd(), 1'b0, V_IDLE, "idle_start");
        step(hold ? 1'b1 : rnd(), rnd(), 1'b0, V_T0, "t0");
        step(hold ? 1'b1 : rnd(), rnd(), 1'b0, V_T1, "t1");
        for (int i = 0; i < TMO; i++) begin
            if (i == abort_at) begin
                start     = 1'b1;
                mem_ready = 1'b0;
                ack_fault = 1'b0;
                cnt_m     = '0;
                exp_q.push_back('{cyc, V_IDLE, 16'h0000, "async_clear"});
                #1 clear_n = 1'b0;
                #6 clear_n = 1'b1;
                @(posedge clock);
                #1;
                return;
            end
            r = (i == d);
            step(hold ? 1'b1 : rnd(), r, 1'b0, r ? V_MWR : V_MW, "mem_wait");
            if (r) break;
        end
        if (d < TMO) begin
            step(hold ? 1'b1 : rnd(), rnd(), 1'b0, V_T2, "t2_done");
            cnt_m = cnt_m + 16'd1;
        end else begin
            repeat ($urandom_range(0, 3)) step(rnd(), rnd(), 1'b0, V_FLT, "fault_hold");
            step(rnd(), rnd(), 1'b1, V_FLT, "fault_ack");
        end
    endtask

    initial begin
        int x;
        @(posedge clock);
        #1;
        step(1'b1, 1'b1, 1'b1, V_IDLE, "reset");
        step(1'b0, 1'b0, 1'b0, V_IDLE, "reset");
        clear_n = 1'b1;
        idle(2);

        fetch(0, -1, 1'b0, 1'b0);
        idle(1);
        fetch(3, -1, 1'b0, 1'b0);
        idle(1);
        fetch(TMO, -1, 1'b0, 1'b0);
        idle(1);
        fetch(TMO - 1, -1, 1'b0, 1'b0);
        idle(1);
        fetch(TMO, 2, 1'b0, 1'b0);
        fetch(0, -1, 1'b1, 1'b0);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            x = $urandom_range(0, 9);
            if (x < 8) fetch($urandom_range(0, TMO - 1), -1, 1'b0, 1'b0);
            else       fetch(TMO, -1, 1'b0, 1'b0);
            idle($urandom_range(0, 2));
        end

        // Preload the count just below wrap instead of running 65535 fetches.
        force dut.fetch_cnt_d = 16'hFFFE;
        idle(1);
        release dut.fetch_cnt_d;
        cnt_m = 16'hFFFE;
        for (int n = 0; n < 3; n++) fetch(0, -1, 1'b0, 1'b1);
        idle(3);

        if (exp_q.size() != 0) begin
            miscompares += exp_q.size();
            $display("FAIL scoreboard_drain got %0d pending entries required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
